// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: controller state encoding, output bundle and canned output patterns
package pipeline_ctrl_pkg;
  typedef enum logic [2:0] {RUN, FLUSH, LOAD_STALL, MC_BUSY, HALTED} ctrl_state_e;
  typedef struct packed {
    logic        fe_en;
    logic        pc_r;
    logic [31:0] pc_exec;
    logic        de_en;
    logic        de_flush;
    logic        ex_hold;
  } ctrl_out_s;
  localparam ctrl_out_s CO_IDLE  = '{fe_en:1'b0, pc_r:1'b0, pc_exec:32'd0, de_en:1'b0, de_flush:1'b0, ex_hold:1'b0};
  localparam ctrl_out_s CO_RUN   = '{fe_en:1'b1, pc_r:1'b0, pc_exec:32'd0, de_en:1'b1, de_flush:1'b0, ex_hold:1'b0};
  localparam ctrl_out_s CO_FLUSH = '{fe_en:1'b1, pc_r:1'b0, pc_exec:32'd0, de_en:1'b1, de_flush:1'b1, ex_hold:1'b0};
  localparam ctrl_out_s CO_STALL = '{fe_en:1'b0, pc_r:1'b0, pc_exec:32'd0, de_en:1'b0, de_flush:1'b1, ex_hold:1'b0};
  localparam ctrl_out_s CO_HOLD  = '{fe_en:1'b0, pc_r:1'b0, pc_exec:32'd0, de_en:1'b0, de_flush:1'b0, ex_hold:1'b1};
  function automatic ctrl_out_s co_redirect(input logic [31:0] addr);
    return '{fe_en:1'b1, pc_r:1'b1, pc_exec:addr, de_en:1'b1, de_flush:1'b1, ex_hold:1'b0};
  endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stall/redirect controls between pipeline and controller
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       de_rs1, de_rs2, ex_rd;
  logic             de_uses_rs1, de_uses_rs2, ex_is_load, ex_rd_we;
  logic             ex_branch_taken, mc_start, mc_done, halt_req, resume;
  logic [31:0]      ex_target, resume_pc, pc_exec;
  logic             fe_en, pc_r, de_en, de_flush, ex_hold, halted, mc_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    input  de_rs1, de_rs2, de_uses_rs1, de_uses_rs2, ex_is_load, ex_rd_we, ex_rd,
           ex_branch_taken, ex_target, mc_start, mc_done, halt_req, resume, resume_pc,
    output fe_en, pc_r, pc_exec, de_en, de_flush, ex_hold, halted, mc_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    output de_rs1, de_rs2, de_uses_rs1, de_uses_rs2, ex_is_load, ex_rd_we, ex_rd,
           ex_branch_taken, ex_target, mc_start, mc_done, halt_req, resume, resume_pc,
    input  fe_en, pc_r, pc_exec, de_en, de_flush, ex_hold, halted, mc_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect: combinational compare of decode sources against an in-flight load destination
module load_use_detect (
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_uses_rs1,
  input  logic       de_uses_rs2,
  input  logic       ex_is_load,
  input  logic       ex_rd_we,
  input  logic [4:0] ex_rd,
  output logic       hazard
);
  assign hazard = ex_is_load && ex_rd_we && ex_rd != 5'd0 &&
                  ((de_uses_rs1 && de_rs1 == ex_rd) || (de_uses_rs2 && de_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush/redirect sequencer with halt, multi-cycle and perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.master bus
);
  localparam int TW = MC_TIMEOUT > 2 ? $clog2(MC_TIMEOUT) : 1;
  ctrl_state_e      st, st_n;
  ctrl_out_s        co;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             hz, tmo;
  load_use_detect u_lud (
    .de_rs1      (bus.de_rs1),
    .de_rs2      (bus.de_rs2),
    .de_uses_rs1 (bus.de_uses_rs1),
    .de_uses_rs2 (bus.de_uses_rs2),
    .ex_is_load  (bus.ex_is_load),
    .ex_rd_we    (bus.ex_rd_we),
    .ex_rd       (bus.ex_rd),
    .hazard      (hz)
  );
  always_comb begin
    co   = CO_IDLE;
    st_n = st;
    tmo  = 1'b0;
    case (st)
      RUN, LOAD_STALL: begin
        if (bus.ex_branch_taken) begin
          co   = co_redirect(bus.ex_target);
          st_n = FLUSH;
        end else if (bus.halt_req) begin
          st_n = HALTED;
        end else if (bus.mc_start) begin
          co   = CO_RUN;
          st_n = MC_BUSY;
        end else if (hz && st == RUN) begin
          co   = CO_STALL;
          st_n = LOAD_STALL;
        end else begin
          co   = CO_RUN;
          st_n = RUN;
        end
      end
      FLUSH: begin
        co   = CO_FLUSH;
        st_n = RUN;
      end
      MC_BUSY: begin
        tmo  = !bus.mc_done && tcnt == TW'(MC_TIMEOUT - 1);
        co   = bus.mc_done || tmo ? CO_RUN : CO_HOLD;
        st_n = bus.mc_done || tmo ? RUN : MC_BUSY;
      end
      HALTED: begin
        co   = bus.resume ? co_redirect(bus.resume_pc) : CO_IDLE;
        st_n = bus.resume ? FLUSH : HALTED;
      end
      default: st_n = RUN;
    endcase
  end
  // outputs are combinational, so reset must mask them to reach all-zero asynchronously
  assign bus.fe_en      = co.fe_en && !reset;
  assign bus.pc_r       = co.pc_r && !reset;
  assign bus.pc_exec    = reset ? 32'd0 : co.pc_exec;
  assign bus.de_en      = co.de_en && !reset;
  assign bus.de_flush   = co.de_flush && !reset;
  assign bus.ex_hold    = co.ex_hold && !reset;
  assign bus.halted     = st == HALTED && !reset;
  assign bus.mc_timeout = tmo && !reset;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= RUN;
      tcnt    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      st   <= st_n;
      tcnt <= st == MC_BUSY && st_n == MC_BUSY ? tcnt + 1'b1 : '0;
      if (!co.fe_en && st != HALTED && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (co.pc_r && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end
endmodule
